// File: rtl/memory_responder.sv
// memory_responder: wait-stated single-port word memory with a 4-phase Req/Ack handshake; MEMRESP_WRITE_PROTECT_EN drops writes below PROTECT_TOP
module memory_responder #(
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] PROTECT_TOP = 16'h0100
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Req,
    input  logic        Write,
    input  logic [15:0] Addr,
    input  logic [15:0] WriteData,
    output logic        Ack,
    output logic [15:0] ReadData,
    output logic        Busy,
    output logic        Error
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [15:0] addr_q, wd_q, ram_q;
    logic wr_q, oor, prot, we;
    logic [ADDR_BITS-1:0] idx;
    logic [15:0] mem [2**ADDR_BITS];
    assign idx = addr_q[ADDR_BITS-1:0];
    assign oor = (addr_q >> ADDR_BITS) != 16'd0;
`ifdef MEMRESP_WRITE_PROTECT_EN
    assign prot = wr_q && !oor && addr_q < PROTECT_TOP;
`else
    logic unused_top;
    assign unused_top = ^PROTECT_TOP;
    assign prot = 1'b0;
`endif
    assign we = state == ACCESS && wr_q && !oor && !prot;
    assign Busy = state != IDLE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = Req ? (WAIT_STATES > 0 ? WAIT : ACCESS) : IDLE;
            WAIT:    state_nx = cnt == 4'd1 ? ACCESS : WAIT;
            ACCESS:  state_nx = DONE;
            default: state_nx = Ack && !Req ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge CLK or negedge Reset)
        if (!Reset) begin
            cnt      <= 4'd0;
            Ack      <= 1'b0;
            Error    <= 1'b0;
            ReadData <= 16'h0000;
            addr_q   <= 16'h0000;
            wd_q     <= 16'h0000;
            wr_q     <= 1'b0;
        end else begin
            if (state == IDLE && Req) begin
                addr_q <= Addr;
                wr_q   <= Write;
                wd_q   <= WriteData;
                cnt    <= 4'(WAIT_STATES);
            end
            if (state == WAIT) cnt <= cnt - 4'd1;
            // the synchronous array read lands in ram_q during ACCESS, so the response registers one edge later
            if (state == DONE && !Ack) begin
                Ack      <= 1'b1;
                Error    <= oor || prot;
                ReadData <= oor ? 16'h0000 : (wr_q && !prot) ? wd_q : ram_q;
            end
            if (state == DONE && Ack && !Req) begin
                Ack   <= 1'b0;
                Error <= 1'b0;
            end
        end
    always_ff @(posedge CLK) begin
        if (we) mem[idx] <= wd_q;
        ram_q <= mem[idx];
    end
endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Memory-side responder for the 16-bit datapath. It accepts the word address chosen by the CPU's memory address selector, plus write data and a request.
- Performs one read or write on an internal word array after a configurable number of wait states.
- Completes each transfer with a 4-phase Req/Ack handshake.
- Sits between the address/data muxes and the register file / IR load paths.

Parameters:
- ADDR_BITS, 10, implemented word-address bits; array depth = 2**ADDR_BITS words.
- WAIT_STATES, 2, extra cycles inserted before the array access (0..15).
- PROTECT_TOP, 16'h0100, first writable address when MEMRESP_WRITE_PROTECT_EN is defined.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  1  transfer request; held high until Ack is seen.
- Write  input  1  1 = write, 0 = read; sampled with Req.
- Addr  input  16  word address from the memory address selector.
- WriteData  input  16  store data; sampled with Req.
- Ack  output  1  transfer complete; held until Req falls.
- ReadData  output  16  read result; valid while Ack = 1.
- Busy  output  1  1 whenever the state is not IDLE.
- Error  output  1  error flag for the completed transfer; valid while Ack = 1.

Behaviour:
- Reset (Reset = 0, asynchronous):
  - state = IDLE; Ack, Busy, Error = 0; ReadData = 16'h0000; wait counter = 0.
  - Array contents are not cleared.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - When Req = 1, latch Addr, Write and WriteData into internal registers.
  - Load the counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES > 0, otherwise go to ACCESS.
  - Inputs are ignored after latching until the next IDLE.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to ACCESS. This gives exactly WAIT_STATES cycles in WAIT.
- ACCESS:
  - Range check: out of range = latched Addr[15:ADDR_BITS] != 0.
  - Out of range: Error = 1, write suppressed, ReadData = 16'h0000.
  - In range, read: ReadData = array[addr].
  - In range, write: array[addr] = data; ReadData = the written data (write-through echo).
  - Go to DONE with Ack = 1.
- DONE:
  - Hold Ack, ReadData and Error stable while Req = 1.
  - When Req = 0, clear Ack and Error and go to IDLE. ReadData holds its value.
- Latency: Req sampled high at edge N causes Ack to rise at edge N + WAIT_STATES + 2.
- Back-to-back transfers: the minimum Req-low time is one cycle. A new Req is sampled at the first edge in IDLE.
- Req dropped before Ack is a protocol violation. The transfer still completes, and DONE exits on the first edge it sees Req = 0.
- Reset mid-transfer: the FSM aborts to IDLE. A write not yet in ACCESS is never performed; a write already done in ACCESS stays committed.
- Array: inferred synchronous RAM, one port, written only in ACCESS.

Optional Feature:
- Macro: MEMRESP_WRITE_PROTECT_EN.
- Defined:
  - An in-range write with latched Addr < PROTECT_TOP is dropped.
  - Error = 1 with Ack, and ReadData returns the current array[addr].
  - Reads are unaffected.
- Undefined: all in-range writes are performed. PROTECT_TOP is unused, and Error is set only for out-of-range addresses.

Test Plan:
- Write then read:
  - Write Addr = 16'h0200, WriteData = 16'hBEEF → Ack at edge N+4, ReadData = 16'hBEEF, Error = 0.
  - Then read 16'h0200 → ReadData = 16'hBEEF.
- Latency sweep: WAIT_STATES = 0 and 5, read 16'h0010 → Ack rises exactly 2 and 7 edges after Req is sampled; Busy high throughout.
- Out of range: ADDR_BITS = 10, write 16'h0400 with 16'h1234 → Error = 1, ReadData = 16'h0000; reading 16'h0000 afterwards is unchanged.
- Handshake hold: keep Req high for 6 cycles after Ack → Ack and ReadData stay stable; Ack falls the cycle after Req falls; next Req is accepted after one idle cycle.
- Reset mid-operation:
  - Write 16'h0300 ← 16'hAAAA, assert Reset during WAIT → Ack, Busy, Error = 0 immediately.
  - After reset, reading 16'h0300 returns the old value.
- Write protect (macro defined):
  - Write 16'h0050 ← 16'h5555 → Error = 1 and the location is unchanged.
  - Write 16'h0100 ← 16'h5555 → Error = 0 and the location is updated.
